// File: rtl/mlp_seq_pkg.sv
// Shared types and widths for the printed-MLP frame sequencer.
package mlp_seq_pkg;

  localparam int unsigned N_FEAT  = 10;
  localparam int unsigned FEAT_W  = 4;
  localparam int unsigned CLS_W   = 2;
  localparam int unsigned INP_W   = N_FEAT * FEAT_W;
  localparam int unsigned IDX_W   = $clog2(N_FEAT);
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SKIP   = 2'd1,
    SETTLE = 2'd2,
    OUT    = 2'd3
  } state_e;

endpackage

// File: rtl/mlp_feat_asm.sv
// Feature assembler: writes one feature per enabled beat into the frame
// register at the current slot index and advances or clears the index.
module mlp_feat_asm
  import mlp_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              clr,
  input  logic [FEAT_W-1:0] data,
  output logic [INP_W-1:0]  frame,
  output logic [IDX_W-1:0]  idx
);

  // Slot write and index bookkeeping; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame <= '0;
      idx   <= '0;
    end else begin
      for (int unsigned k = 0; k < N_FEAT; k++) begin
        if (we && (idx == IDX_W'(k))) begin
          frame[k*FEAT_W +: FEAT_W] <= data;
        end
      end
      if (clr) begin
        idx <= '0;
      end else if (we) begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/mlp_frame_sequencer.sv
// Sequential wrapper around a combinational printed-MLP classifier:
// assembles a feature frame, holds it for SETTLE_CYC cycles, then
// captures the class and offers it on a valid/ready result port.
// Optional MLP_FRAME_CNT_EN adds frame_cnt / err_cnt statistics outputs.
module mlp_frame_sequencer
  import mlp_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [FEAT_W-1:0] s_data,
  input  logic              s_last,
  output logic [INP_W-1:0]  mlp_inp,
  input  logic [CLS_W-1:0]  mlp_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CLS_W-1:0]  m_class,
  output logic              frame_err
`ifdef MLP_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic [7:0]        err_cnt
`endif
);

  if ((SETTLE_CYC < 1) || (SETTLE_CYC > CNT_MAX)) begin : g_settle_range_err
    $error("SETTLE_CYC must be within 1..255");
  end

  state_e             state_q;
  state_e             state_d;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   cnt_q;
  logic               s_xfer;
  logic               idx_last;
  logic               asm_we;
  logic               asm_clr;
  logic               err_d;
  logic               cnt_load;
  logic               capture;
  logic               res_done;

  assign s_xfer   = s_valid && s_ready;
  assign idx_last = (idx == IDX_W'(N_FEAT - 1));

  mlp_feat_asm u_feat_asm (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (asm_we),
    .clr   (asm_clr),
    .data  (s_data),
    .frame (mlp_inp),
    .idx   (idx)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD: begin
        if (s_xfer && idx_last) begin
          state_d = s_last ? SETTLE : SKIP;
        end
      end
      SKIP: begin
        if (s_xfer && s_last) begin
          state_d = LOAD;
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = OUT;
        end
      end
      OUT: begin
        if (m_valid && m_ready) begin
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Per-state control strobes; s_ready is combinational from state.
  always_comb begin
    s_ready  = 1'b0;
    asm_we   = 1'b0;
    asm_clr  = 1'b0;
    err_d    = 1'b0;
    cnt_load = 1'b0;
    capture  = 1'b0;
    res_done = 1'b0;
    unique case (state_q)
      LOAD: begin
        s_ready  = 1'b1;
        asm_we   = s_valid;
        asm_clr  = s_valid && (s_last || idx_last);
        err_d    = s_valid && (s_last != idx_last);
        cnt_load = s_valid && s_last && idx_last;
      end
      SKIP: begin
        s_ready = 1'b1;
      end
      SETTLE: begin
        capture = (cnt_q == CNT_W'(1));
      end
      OUT: begin
        res_done = m_valid && m_ready;
      end
      default: ;
    endcase
  end

  // Settle countdown: loaded on the final good beat, counts down in SETTLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_load) begin
      cnt_q <= CNT_W'(SETTLE_CYC);
    end else if ((state_q == SETTLE) && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Result register and framing-error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid   <= 1'b0;
      m_class   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= err_d;
      if (capture) begin
        m_valid <= 1'b1;
        m_class <= mlp_out;
      end else if (res_done) begin
        m_valid <= 1'b0;
      end
    end
  end

`ifdef MLP_FRAME_CNT_EN
  // Statistics: wrapping result count and saturating error count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (res_done) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (frame_err && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mlp_frame_sequencer.sv
// Directed self-checking bench for mlp_frame_sequencer (SETTLE_CYC = 4).
module tb_mlp_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [3:0]  s_data = 4'h0;
  logic        s_last = 1'b0;
  logic [39:0] mlp_inp;
  logic [1:0]  mlp_out = 2'b00;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [1:0]  m_class;
  logic        frame_err;
`ifdef MLP_FRAME_CNT_EN
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mlp_frame_sequencer #(.SETTLE_CYC(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .mlp_inp   (mlp_inp),
    .mlp_out   (mlp_out),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_class   (m_class),
    .frame_err (frame_err)
`ifdef MLP_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
`endif
  );

  // Present one beat at a negedge, wait (bounded) for s_ready, let it transfer.
  task automatic send_beat(input logic [3:0] d, input logic last);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (s_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL beat_accept_timeout s_ready=%b required 1", s_ready);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [39:0] f);
    for (int k = 0; k < 10; k++) begin
      send_beat(f[4*k +: 4], (k == 9));
    end
  endtask

  // Wait (bounded) for a result, check it, then handshake it.
  task automatic take_result(input logic [1:0] exp_cls);
    int n = 0;
    while (m_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (m_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL result_timeout m_valid=%b required 1", m_valid);
    end
    compared++;
    if (m_class !== exp_cls) begin
      mismatched++;
      $display("FAIL result_class m_class=%b required %b", m_class, exp_cls);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    compared++;
    if (m_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL result_release m_valid=%b required 0", m_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    compared++;
    if ({s_ready, m_valid, frame_err, m_class} !== 5'b10000) begin
      mismatched++;
      $display("FAIL reset_ctrl s_ready/m_valid/frame_err/m_class=%b required 10000",
               {s_ready, m_valid, frame_err, m_class});
    end
    compared++;
    if (mlp_inp !== 40'h0) begin
      mismatched++;
      $display("FAIL reset_inp mlp_inp=%h required 0", mlp_inp);
    end
`ifdef MLP_FRAME_CNT_EN
    compared++;
    if (frame_cnt !== 16'h0 || err_cnt !== 8'h0) begin
      mismatched++;
      $display("FAIL reset_cnt frame_cnt=%h err_cnt=%h required 0 0", frame_cnt, err_cnt);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    mlp_out = 2'b10;
    send_frame(40'hA987654321);
    compared++;
    if (mlp_inp !== 40'hA987654321) begin
      mismatched++;
      $display("FAIL nominal_inp mlp_inp=%h required a987654321", mlp_inp);
    end
    compared++;
    if (m_valid !== 1'b0 || s_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL nominal_settle_start m_valid=%b s_ready=%b required 0 0", m_valid, s_ready);
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      compared++;
      if (m_valid !== (k == 4)) begin
        mismatched++;
        $display("FAIL nominal_latency edge=%0d m_valid=%b required %b", k, m_valid, (k == 4));
      end
    end
    compared++;
    if (m_class !== 2'b10) begin
      mismatched++;
      $display("FAIL nominal_class m_class=%b required 10", m_class);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    compared++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL nominal_handshake m_valid=%b s_ready=%b required 0 1", m_valid, s_ready);
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    mlp_out = 2'b01;
    send_frame(40'h3333333333);
    while (m_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    s_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      mlp_out = 2'(i);
      s_data  = 4'(i);
      @(negedge clk);
      compared++;
      if (m_class !== 2'b01 || m_valid !== 1'b1 || s_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL bp_hold cyc=%0d m_class=%b m_valid=%b s_ready=%b required 01 1 0",
                 i, m_class, m_valid, s_ready);
      end
    end
    s_valid = 1'b0;
    compared++;
    if (mlp_inp !== 40'h3333333333) begin
      mismatched++;
      $display("FAIL bp_inp_frozen mlp_inp=%h required 3333333333", mlp_inp);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    compared++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL bp_handshake m_valid=%b s_ready=%b required 0 1", m_valid, s_ready);
    end
  endtask

  task automatic test_early_last();
    int errs = 0;
    int vals = 0;
    mlp_out = 2'b11;
    for (int k = 0; k < 4; k++) send_beat(4'h7, 1'b0);
    send_beat(4'h7, 1'b1);
    compared++;
    if (frame_err !== 1'b1) begin
      mismatched++;
      $display("FAIL early_err_pulse frame_err=%b required 1", frame_err);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      errs += int'(frame_err);
      vals += int'(m_valid);
    end
    compared++;
    if (errs != 0 || vals != 0) begin
      mismatched++;
      $display("FAIL early_quiet extra_err=%0d m_valid_cycles=%0d required 0 0", errs, vals);
    end
    send_frame(40'hFFFFFFFFFF);
    compared++;
    if (mlp_inp !== 40'hFFFFFFFFFF) begin
      mismatched++;
      $display("FAIL early_next_inp mlp_inp=%h required ffffffffff", mlp_inp);
    end
    take_result(2'b11);
  endtask

  task automatic test_reset_mid();
    int vals = 0;
    int errs = 0;
    logic [1:0] got = 2'b00;
    mlp_out = 2'b10;
    for (int k = 0; k < 6; k++) send_beat(4'h5, 1'b0);
    rst_n = 1'b0;
    #1;
    compared++;
    if ({s_ready, m_valid, frame_err, m_class} !== 5'b10000 || mlp_inp !== 40'h0) begin
      mismatched++;
      $display("FAIL midreset_vals ctrl=%b mlp_inp=%h required 10000 0",
               {s_ready, m_valid, frame_err, m_class}, mlp_inp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(40'h0123456789);
    compared++;
    if (mlp_inp !== 40'h0123456789) begin
      mismatched++;
      $display("FAIL midreset_inp mlp_inp=%h required 0123456789", mlp_inp);
    end
    m_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (m_valid) got = m_class;
      vals += int'(m_valid);
      errs += int'(frame_err);
    end
    m_ready = 1'b0;
    compared++;
    if (vals != 1 || errs != 0 || got !== 2'b10) begin
      mismatched++;
      $display("FAIL midreset_result results=%0d errs=%0d class=%b required 1 0 10", vals, errs, got);
    end
  endtask

  task automatic test_overlong();
    int errs = 0;
    mlp_out = 2'b01;
    for (int k = 0; k < 10; k++) send_beat(4'h2, 1'b0);
    compared++;
    if (frame_err !== 1'b1 || s_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL overlong_err frame_err=%b s_ready=%b required 1 1", frame_err, s_ready);
    end
    for (int k = 0; k < 3; k++) begin
      send_beat(4'hC, (k == 2));
      errs += int'(frame_err);
    end
    compared++;
    if (errs != 0 || m_valid !== 1'b0 || mlp_inp !== 40'h2222222222) begin
      mismatched++;
      $display("FAIL overlong_skip errs=%0d m_valid=%b mlp_inp=%h required 0 0 2222222222",
               errs, m_valid, mlp_inp);
    end
    mlp_out = 2'b00;
    send_frame(40'h9876543210);
    compared++;
    if (mlp_inp !== 40'h9876543210) begin
      mismatched++;
      $display("FAIL overlong_next_inp mlp_inp=%h required 9876543210", mlp_inp);
    end
    take_result(2'b00);
  endtask

`ifdef MLP_FRAME_CNT_EN
  task automatic test_counters();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mlp_out = 2'b01;
    for (int f = 0; f < 3; f++) begin
      send_frame(40'h1111111111);
      take_result(2'b01);
    end
    send_beat(4'h1, 1'b0);
    send_beat(4'h1, 1'b1);
    for (int k = 0; k < 11; k++) send_beat(4'h1, (k == 10));
    repeat (3) @(negedge clk);
    compared++;
    if (frame_cnt !== 16'd3 || err_cnt !== 8'd2) begin
      mismatched++;
      $display("FAIL counters frame_cnt=%0d err_cnt=%0d required 3 2", frame_cnt, err_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_early_last();
    test_reset_mid();
    test_overlong();
`ifdef MLP_FRAME_CNT_EN
    test_counters();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
